// File: rtl/fft_frame_feeder_if.sv
// Signal bundle between the audio sample source, fft_frame_feeder and the FFT core.
// The feeder connects through the master modport; the source/FFT side uses slave.
interface fft_frame_feeder_if #(
    parameter int unsigned NFFT        = 512,
    parameter int unsigned INPUT_WIDTH = 16
);
    logic                          sample_valid_i;
    logic signed [INPUT_WIDTH-1:0] sample_i;
    logic                          sample_ready_o;
    logic                          fft_done_i;
    logic                          out_valid_o;
    logic [$clog2(NFFT)-1:0]       frame_ptr_o;
    logic signed [INPUT_WIDTH-1:0] real_out_o;
    logic                          start_o;
    logic                          busy_o;
    logic [15:0]                   frame_count_o;

    modport master (
        input  sample_valid_i, sample_i, fft_done_i,
        output sample_ready_o, out_valid_o, frame_ptr_o, real_out_o, start_o, busy_o,
               frame_count_o
    );

    modport slave (
        output sample_valid_i, sample_i, fft_done_i,
        input  sample_ready_o, out_valid_o, frame_ptr_o, real_out_o, start_o, busy_o,
               frame_count_o
    );
endinterface

// File: rtl/fft_frame_feeder.sv
// Buffers a sample stream in a circular buffer and emits overlapping, zero-padded
// NFFT-beat frames (advancing by HOP_SIZE) to an FFT, one frame per fft_done handshake.
module fft_frame_feeder #(
    parameter int unsigned NFFT        = 512,
    parameter int unsigned INPUT_WIDTH = 16,
    parameter int unsigned FRAME_SIZE  = 306,
    parameter int unsigned HOP_SIZE    = 128,
    parameter int unsigned BUF_DEPTH   = 512
) (
    input logic               clk,
    input logic               rst,
    fft_frame_feeder_if.master bus
);
    localparam int unsigned PW = $clog2(NFFT);
    localparam int unsigned AW = $clog2(BUF_DEPTH);
    localparam int unsigned FW = $clog2(BUF_DEPTH + 1);
    localparam int unsigned CW = $clog2(NFFT + 1);

    typedef enum logic [1:0] {StIdle, StStream, StStart, StWaitDone} state_e;

    state_e                 state_q, state_d;
    logic [INPUT_WIDTH-1:0] mem [BUF_DEPTH];
    logic [AW-1:0]          wr_ptr_q, rd_base_q, rd_addr;
    logic [FW-1:0]          fill_q, fill_d;
    logic [CW-1:0]          beat_q, beat_d;
    logic [15:0]            frame_count_q;
    logic                   out_valid_q;
    logic [PW-1:0]          frame_ptr_q;
    logic [INPUT_WIDTH-1:0] real_out_q;
    logic                   accept, issue, hop;

    assign bus.sample_ready_o = (fill_q < FW'(BUF_DEPTH));
    assign accept             = bus.sample_valid_i && bus.sample_ready_o;
    // STREAM lasts NFFT+1 cycles: NFFT reads plus one cycle for the last read to land.
    assign issue              = (state_q == StStream) && (beat_q < CW'(NFFT));
    assign rd_addr            = rd_base_q + AW'(beat_q);

    assign bus.out_valid_o   = out_valid_q;
    assign bus.frame_ptr_o   = frame_ptr_q;
    assign bus.real_out_o    = real_out_q;
    assign bus.start_o       = (state_q == StStart);
    assign bus.busy_o        = (state_q != StIdle);
    assign bus.frame_count_o = frame_count_q;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        hop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                beat_d = '0;
                if (fill_q >= FW'(FRAME_SIZE)) state_d = StStream;
            end
            StStream: begin
                if (beat_q == CW'(NFFT)) state_d = StStart;
                else                     beat_d  = beat_q + CW'(1);
            end
            StStart: state_d = StWaitDone;
            StWaitDone: begin
                if (bus.fft_done_i) begin
                    hop     = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        fill_d = fill_q + FW'(accept) - (hop ? FW'(HOP_SIZE) : FW'(0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            beat_q        <= '0;
            fill_q        <= '0;
            wr_ptr_q      <= '0;
            rd_base_q     <= '0;
            frame_count_q <= '0;
            out_valid_q   <= 1'b0;
            frame_ptr_q   <= '0;
            real_out_q    <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            fill_q      <= fill_d;
            if (accept) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (hop) begin
                rd_base_q     <= rd_base_q + AW'(HOP_SIZE);
                frame_count_q <= frame_count_q + 16'd1;
            end
            out_valid_q <= issue;
            frame_ptr_q <= issue ? PW'(beat_q) : '0;
            real_out_q  <= (issue && (beat_q < CW'(FRAME_SIZE))) ? mem[rd_addr] : '0;
        end
    end

    // Never collides with a live frame entry: writes are gated by fill < BUF_DEPTH.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr_q] <= bus.sample_i;
    end
endmodule

// File: doc/fft_frame_feeder.md
FFT_FRAME_FEEDER -- requirements
Module: fft_frame_feeder

Interface
REQ-001 SHALL have parameter NFFT, default 512, FFT length and beats emitted per frame.
REQ-002 SHALL have parameter INPUT_WIDTH, default 16, signed sample width.
REQ-003 SHALL have parameter FRAME_SIZE, default 306, real samples per frame; the remaining NFFT-FRAME_SIZE beats are zero padding.
REQ-004 SHALL have parameter HOP_SIZE, default 128, sample advance between consecutive frames.
REQ-005 SHALL have parameter BUF_DEPTH, default 512, circular buffer depth, power of two, >= FRAME_SIZE+HOP_SIZE.
REQ-006 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-008 SHALL have port: sample_valid_i  input  1  audio sample present.
REQ-009 SHALL have port: sample_i  input  INPUT_WIDTH  signed audio sample.
REQ-010 SHALL have port: sample_ready_o  output  1  buffer can accept; a sample is written only when sample_valid_i and sample_ready_o are both high.
REQ-011 SHALL have port: fft_done_i  input  1  one-cycle pulse from the FFT when the power spectrum is finished.
REQ-012 SHALL have port: out_valid_o  output  1  frame beat valid, drives the FFT in_valid.
REQ-013 SHALL have port: frame_ptr_o  output  $clog2(NFFT)  beat index in natural order; the FFT applies bit reversal.
REQ-014 SHALL have port: real_out_o  output  INPUT_WIDTH  beat sample.
REQ-015 SHALL have port: start_o  output  1  one-cycle FFT start pulse.
REQ-016 SHALL have port: busy_o  output  1  high in any state other than IDLE.
REQ-017 SHALL have port: frame_count_o  output  16  completed frames, wraps modulo 2^16.

Function
REQ-018 SHALL keep write pointer wr_ptr, frame base rd_base and occupancy fill (0..BUF_DEPTH), measured from rd_base.
REQ-019 SHALL drive sample_ready_o = (fill < BUF_DEPTH) combinationally, in every state.
REQ-020 SHALL, on an accepted sample, write buf[wr_ptr], increment wr_ptr modulo BUF_DEPTH and increment fill.
REQ-021 SHALL implement FSM IDLE -> STREAM -> START -> WAIT_DONE -> IDLE.
REQ-022 IDLE: SHALL move to STREAM on the edge where fill >= FRAME_SIZE.
REQ-023 STREAM: SHALL issue exactly NFFT beats on consecutive cycles, with no gaps.
REQ-024 STREAM: the first beat SHALL have out_valid_o high in the cycle after STREAM is entered; this is one synchronous buffer-read stage.
REQ-025 Beat n, 0..NFFT-1, SHALL have frame_ptr_o=n; real_out_o SHALL be buf[(rd_base+n) mod BUF_DEPTH] for n<FRAME_SIZE, else 0.
REQ-026 START: SHALL assert start_o for exactly one cycle, the cycle immediately after the last beat; out_valid_o SHALL be low in that cycle.
REQ-027 WAIT_DONE: on fft_done_i, SHALL advance rd_base by HOP_SIZE modulo BUF_DEPTH, reduce fill by HOP_SIZE, increment frame_count_o, and return to IDLE.
REQ-028 fft_done_i outside WAIT_DONE SHALL be ignored.
REQ-029 SHALL compute fill as fill+1-HOP_SIZE when a sample is accepted in the same cycle as the hop release.
REQ-030 SHALL never overwrite entries in [rd_base, rd_base+fill); this is guaranteed by REQ-019.
REQ-031 SHALL hold out_valid_o, start_o, frame_ptr_o and real_out_o at 0 outside their defined cycles.

Reset
REQ-032 SHALL, while rst is high at a clock edge, set state IDLE and clear wr_ptr, rd_base, fill, frame_count_o, out_valid_o, start_o, frame_ptr_o and real_out_o to 0.
REQ-033 SHALL let rst abort any state, including mid-STREAM; no further beats or start_o pulse SHALL follow.
REQ-034 Buffer contents need no reset; sample_ready_o SHALL read 1 in the first cycle after reset.

Verification
REQ-035 Ramp sample_i=1,2,3,... continuously -> beats 0..305 carry 1..306, beats 306..511 carry 0, and start_o pulses exactly 1 cycle after beat 511.
REQ-036 After REQ-035, pulse fft_done_i -> frame_count_o=1; the second frame's beat 0 carries 129 and beat 305 carries 434.
REQ-037 Withhold fft_done_i while streaming 600 samples -> sample_ready_o falls at fill=512, and no sample is lost or overwritten once done arrives.
REQ-038 Accept a sample in the same cycle as fft_done_i with fill=306 -> fill=179.
REQ-039 Assert rst at beat 100 -> out_valid_o=0 on the next cycle, no start_o pulse, frame_count_o=0, and a fresh ramp is framed from value 1.
REQ-040 Pulse fft_done_i in IDLE and in STREAM -> no state change and frame_count_o unchanged.
